// File: rtl/sprite_line_fetcher.sv
// rtl/sprite_line_fetcher.sv - fetches one sprite row per hblank into a ping-pong
// line buffer and serves per-pixel colour/coverage during active video.
module sprite_line_fetcher #(
  parameter int          SPRITE_W    = 64,
  parameter int          SPRITE_H    = 32,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic [9:0]  hcount,
  output logic        pix_valid,
  output logic [15:0] pix_color,
  output logic        busy,
  output logic        fetch_done
);

  localparam int COL_W = $clog2(SPRITE_W);

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

  state_t             state_q;
  logic [COL_W-1:0]   col_q;
  logic [9:0]         row_q;
  logic [9:0]         x_lat_q;
  logic [9:0]         front_x_q;
  logic [10:0]        rom_addr_q;
  logic               sel_q;
  logic               front_hit_q;
  logic               miss_done_q;
  logic               pix_valid_q;
  logic [15:0]        pix_color_q;

  // Buffer half sel_q is the front (display) row; ~sel_q is filled by the fetch.
  logic [15:0]        line_mem [0:2*SPRITE_W-1];

  logic [9:0]         row_d;
  logic               hit_d;
  logic               last_col_d;
  logic               wr_en_d;
  logic [COL_W-1:0]   wr_col_d;
  logic [9:0]         pix_off_d;
  logic               in_sprite_d;
  logic [15:0]        front_pix_d;

  function automatic logic [10:0] row_addr(input logic [9:0] r, input logic [COL_W-1:0] c);
    return 11'(r) * 11'(SPRITE_W) + 11'(c);
  endfunction

  // Modulo subtraction: lines above the sprite wrap to large values and miss.
  assign row_d      = next_line - sprite_y;
  assign hit_d      = row_d < 10'(SPRITE_H);
  assign last_col_d = col_q == COL_W'(SPRITE_W - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      x_lat_q     <= '0;
      front_x_q   <= '0;
      rom_addr_q  <= '0;
      sel_q       <= 1'b0;
      front_hit_q <= 1'b0;
      miss_done_q <= 1'b0;
    end else begin
      miss_done_q <= 1'b0;
      if (line_start) begin
        // A new pulse always wins, even over a fetch about to commit.
        row_q   <= row_d;
        x_lat_q <= sprite_x;
        col_q   <= '0;
        if (hit_d) begin
          state_q    <= FETCH;
          rom_addr_q <= row_addr(row_d, '0);
        end else begin
          state_q     <= IDLE;
          miss_done_q <= 1'b1;
          sel_q       <= ~sel_q;
          front_hit_q <= 1'b0;
        end
      end else begin
        case (state_q)
          FETCH: begin
            col_q <= col_q + 1'b1;
            if (last_col_d) begin
              state_q <= LAST;
            end else begin
              rom_addr_q <= row_addr(row_q, col_q + 1'b1);
            end
          end
          LAST: begin
            sel_q       <= ~sel_q;
            front_hit_q <= 1'b1;
            front_x_q   <= x_lat_q;
            state_q     <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // ROM data lags the address by one cycle, so column col-1 lands while col is
  // addressed; in LAST col has wrapped to 0 and col-1 is the final column.
  assign wr_en_d  = (state_q == FETCH && col_q != '0) || state_q == LAST;
  assign wr_col_d = col_q - 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      line_mem[{~sel_q, wr_col_d}] <= rom_data;
    end
  end

  assign pix_off_d   = hcount - front_x_q;
  assign in_sprite_d = front_hit_q && pix_off_d < 10'(SPRITE_W);
  assign front_pix_d = line_mem[{sel_q, pix_off_d[COL_W-1:0]}];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else if (in_sprite_d && front_pix_d != TRANSPARENT) begin
      pix_valid_q <= 1'b1;
      pix_color_q <= front_pix_d;
    end else begin
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign busy       = state_q != IDLE;
  assign fetch_done = miss_done_q | (state_q == LAST && !line_start);
  assign pix_valid  = pix_valid_q;
  assign pix_color  = pix_color_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb/tb_sprite_line_fetcher.sv - directed and randomized checks of sprite_line_fetcher
// against a row-level reference model.
module tb_sprite_line_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        line_start;
  logic [9:0]  next_line;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [9:0]  hcount;
  logic        pix_valid;
  logic [15:0] pix_color;
  logic        busy;
  logic        fetch_done;

  always #5 clk = ~clk;

  sprite_line_fetcher dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .next_line  (next_line),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .hcount     (hcount),
    .pix_valid  (pix_valid),
    .pix_color  (pix_color),
    .busy       (busy),
    .fetch_done (fetch_done)
  );

  logic [15:0] rom [0:2047];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_front [0:63];
  logic        m_hit;
  logic [9:0]  m_x;
  logic [10:0] m_addr;
  logic [9:0]  last_h;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_h(input logic [9:0] h);
    hcount = h;
    last_h = h;
  endtask

  task automatic check_pix(input string tag, input logic [9:0] h);
    logic [9:0]  off;
    logic [5:0]  idx;
    logic [15:0] c;
    logic        ev;
    logic [15:0] ec;
    off = h - m_x;
    idx = off[5:0];
    ev  = 1'b0;
    ec  = 16'h0000;
    if (m_hit && off < 10'd64) begin
      c = m_front[idx];
      if (c != 16'hF81F) begin
        ev = 1'b1;
        ec = c;
      end
    end
    check({tag, "_valid"}, 32'(pix_valid), 32'(ev));
    check({tag, "_color"}, 32'(pix_color), 32'(ec));
  endtask

  task automatic pix_at(input logic [9:0] h, input logic ev, input logic [15:0] ec);
    set_h(h);
    @(posedge clk); #1;
    check("pix_at_valid", 32'(pix_valid), 32'(ev));
    check("pix_at_color", 32'(pix_color), 32'(ec));
  endtask

  task automatic sweep();
    for (int h = 0; h < 640; h++) begin
      set_h(10'(h));
      @(posedge clk); #1;
      check_pix("sweep", 10'(h));
    end
  endtask

  task automatic start_pulse(input logic [9:0] nl, input logic [9:0] sx, input logic [9:0] sy);
    next_line  = nl;
    sprite_x   = sx;
    sprite_y   = sy;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  // Cycles 1..n after a hit pulse: address sequence, busy, no done, old row displayed.
  task automatic fetch_cycles(input logic [10:0] base, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("rom_addr", 32'(rom_addr), 32'(base) + 32'(k - 1));
      check("busy_fetch", 32'(busy), 32'd1);
      check("fetch_done_early", 32'(fetch_done), 32'd0);
      check_pix("pix_during_fetch", last_h);
      set_h(10'(m_x + 10'($urandom_range(0, 72)) - 10'd4));
      @(posedge clk); #1;
    end
  endtask

  task automatic fetch_tail(input logic [10:0] base, input logic [9:0] sx);
    @(negedge clk);
    check("fetch_done_last", 32'(fetch_done), 32'd1);
    check("busy_last", 32'(busy), 32'd1);
    check_pix("pix_at_last", last_h);
    for (int i = 0; i < 64; i++) m_front[i] = rom[32'(base) + i];
    m_hit  = 1'b1;
    m_x    = sx;
    m_addr = base + 11'd63;
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch_done_after", 32'(fetch_done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("rom_addr_hold", 32'(rom_addr), 32'(m_addr));
    @(posedge clk); #1;
  endtask

  task automatic check_miss();
    @(negedge clk);
    check("miss_done", 32'(fetch_done), 32'd1);
    check("miss_busy", 32'(busy), 32'd0);
    check("miss_rom_addr", 32'(rom_addr), 32'(m_addr));
    m_hit = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("miss_done_pulse", 32'(fetch_done), 32'd0);
    check("miss_rom_addr2", 32'(rom_addr), 32'(m_addr));
    @(posedge clk); #1;
  endtask

  task automatic do_line(input logic [9:0] nl, input logic [9:0] sx, input logic [9:0] sy);
    logic [9:0]  row;
    logic [10:0] base;
    row  = nl - sy;
    base = 11'(row * 64);
    start_pulse(nl, sx, sy);
    if (row < 10'd32) begin
      fetch_cycles(base, 64);
      fetch_tail(base, sx);
    end else begin
      check_miss();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    line_start = 1'b0;
    next_line  = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    set_h(10'd0);
    m_hit  = 1'b0;
    m_x    = '0;
    m_addr = '0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'(i);
    for (int i = 0; i < 64; i++) m_front[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fetch_done", 32'(fetch_done), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_pix_valid", 32'(pix_valid), 32'd0);
    check("reset_pix_color", 32'(pix_color), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    sweep();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rom_addr", 32'(rom_addr), 32'd0);

    // Row 5 of sprite at y=100, x=200, ROM[i]=i.
    do_line(10'd105, 10'd200, 10'd100);
    pix_at(10'd200, 1'b1, 16'd320);
    pix_at(10'd263, 1'b1, 16'd383);
    pix_at(10'd264, 1'b0, 16'd0);
    sweep();

    // Misses: wrapped row above the sprite, and first row below it.
    do_line(10'd99, 10'd200, 10'd100);
    sweep();
    do_line(10'd132, 10'd200, 10'd100);
    sweep();

    // Transparent key colour.
    rom[5*64+10] = 16'hF81F;
    do_line(10'd5, 10'd0, 10'd0);
    pix_at(10'd10, 1'b0, 16'h0000);
    pix_at(10'd11, 1'b1, 16'd331);
    pix_at(10'd9, 1'b1, 16'd329);

    // Restart at col 30 with row 7.
    start_pulse(10'd5, 10'd300, 10'd0);
    fetch_cycles(11'd320, 30);
    check("abort_col30_addr", 32'(rom_addr), 32'd350);
    start_pulse(10'd7, 10'd100, 10'd0);
    fetch_cycles(11'd448, 64);
    fetch_tail(11'd448, 10'd100);
    sweep();

    // Restart coinciding with LAST: no commit of the first row.
    start_pulse(10'd3, 10'd50, 10'd0);
    fetch_cycles(11'd192, 64);
    next_line  = 10'd9;
    sprite_x   = 10'd60;
    sprite_y   = 10'd0;
    line_start = 1'b1;
    @(negedge clk);
    check("last_restart_no_done", 32'(fetch_done), 32'd0);
    @(posedge clk); #1;
    line_start = 1'b0;
    fetch_cycles(11'd576, 64);
    fetch_tail(11'd576, 10'd60);

    // Reset at col 40, then a fresh hit.
    start_pulse(10'd12, 10'd20, 10'd0);
    fetch_cycles(11'd768, 40);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_hit  = 1'b0;
    m_addr = '0;
    check("midreset_rom_addr", 32'(rom_addr), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_fetch_done", 32'(fetch_done), 32'd0);
    check("midreset_pix_valid", 32'(pix_valid), 32'd0);
    check("midreset_pix_color", 32'(pix_color), 32'd0);
    sweep();
    do_line(10'd20, 10'd400, 10'd0);
    sweep();

    // Randomized rows, positions and ROM contents.
    for (int it = 0; it < 8; it++) begin
      logic [9:0] sy;
      logic [9:0] nl;
      logic [9:0] sx;
      for (int i = 0; i < 2048; i++)
        rom[i] = ($urandom_range(0, 7) == 0) ? 16'hF81F : 16'($urandom);
      sy = 10'($urandom_range(0, 1023));
      nl = (it % 4 == 3) ? 10'($urandom_range(0, 1023)) : 10'(sy + 10'($urandom_range(0, 40)));
      sx = 10'($urandom_range(0, 639));
      do_line(nl, sx, sy);
      sweep();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Reader side of the 64x32 RGB565 sprite ROMs (2048 x 16, 11-bit address, one-cycle registered read). During horizontal blanking it fetches the one sprite row that intersects the upcoming scanline into a ping-pong line buffer. During active video it serves per-pixel colour and coverage to the VGA compositor. It sits between the game-state registers (sprite position), the VGA timing counters and one sprite ROM instance.

## Interface
- SPRITE_W, 64, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in rows
- TRANSPARENT, 16'hF81F, RGB565 key colour treated as "no pixel"
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- line_start  in  1  one-cycle pulse at start of hblank; samples next_line, sprite_x, sprite_y
- next_line  in  10  scanline to be displayed after this hblank
- sprite_x  in  10  sprite left column
- sprite_y  in  10  sprite top row
- rom_addr  out  11  ROM address; ROM data valid one clk later
- rom_data  in  16  ROM read data
- hcount  in  10  current active-video column
- pix_valid  out  1  sprite covers hcount and pixel is not TRANSPARENT
- pix_color  out  16  RGB565 colour; 16'h0000 when pix_valid=0
- busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse when a new row (hit or miss) is committed

## Operation
- State machine: IDLE, FETCH, LAST.
- IDLE: on line_start, latch the inputs and compute row = next_line - sprite_y (10-bit, modulo). Hit when row < SPRITE_H (unsigned compare, so lines above the sprite wrap large and miss).
  - Miss: stay IDLE, no ROM reads. Next cycle: fetch_done=1, swap buffers, front_hit=0.
  - Hit: go to FETCH with col=0.
- FETCH: rom_addr = row*SPRITE_W + col, col increments each cycle. Each cycle with col>0, write rom_data to back[col-1]. After col=SPRITE_W-1, go to LAST.
- LAST: write rom_data to back[SPRITE_W-1], swap front/back, set front_hit=1, latch front_x=sprite_x, pulse fetch_done, go to IDLE.
- busy=1 in FETCH and LAST.
- rom_addr holds its last value when not fetching; 0 after reset.
- Display path, registered: off = hcount - front_x (10-bit). Next cycle:
  - pix_color = front[off] when front_hit and off < SPRITE_W.
  - pix_valid = that condition and colour != TRANSPARENT.
  - Otherwise pix_valid=0 and pix_color=0.
- line_start while busy: abort the current fetch, relatch inputs, restart from col=0 (or take the miss path). The aborted fetch produces no fetch_done, and the front buffer and front_hit are unchanged.
- Front buffer is never written. The display path is unaffected by an in-progress fetch.

## Timing
- Reset (reset_n=0 at a clk edge), including mid-fetch:
  - state=IDLE, col=0, rom_addr=0.
  - busy=0, fetch_done=0, pix_valid=0, pix_color=0.
  - front_hit=0, buffer select=0. Buffer contents are don't-care.
- Hit, line_start at edge 0:
  - Addresses base+0..base+63 on cycles 1..64.
  - LAST on cycle 65. fetch_done high cycle 65.
  - New row visible to the display path from cycle 66.
- Miss, line_start at edge 0: fetch_done high cycle 1.
- Minimum hblank at 50 MHz clk / 25 MHz pixel is 320 clk, well above the 65-cycle fetch.
- Display latency: hcount to pix_valid/pix_color is exactly 1 clk.
- line_start simultaneous with LAST: the restart wins. No swap and no fetch_done.

## Test plan
- Reset then idle, hcount sweep 0..639 -> pix_valid=0 and pix_color=0 throughout; busy=0; rom_addr=0.
- sprite_y=100, next_line=105, sprite_x=200, ROM[i]=i -> rom_addr 320..383 on cycles 1..64; fetch_done cycle 65. Then hcount=200 -> pix_color=320 next cycle; hcount=263 -> 383; hcount=264 -> pix_valid=0.
- next_line=99 (row wraps to 1023) and next_line=132 (row 32) -> no ROM reads; fetch_done cycle 1; pix_valid=0 across the whole line.
- ROM[5*64+10]=16'hF81F on a hit row 5, sprite_x=0 -> hcount=10 gives pix_valid=0; hcount=11 gives valid ROM colour.
- Second line_start at FETCH col=30 with next_line for row 7 -> addresses restart at 448; exactly one fetch_done, 65 cycles after the second pulse; the previous front row is still displayed until then.
- reset_n=0 at col=40, then a fresh hit -> pix_valid=0 until the new fetch_done; then correct row.
